uart_fifo_gen: RTL and testbench

Parametrised synchronous FIFO for the UART transmit and receive byte paths, and the next generation of the existing fixed-width byte FIFO. It is generic in data width and depth and uses every storage slot. It adds a selectable overwrite-oldest mode, sticky overflow and underflow flags, a read-valid strobe, and optional triple-modular-redundant (TMR) pointer protection for radiation-tolerant builds. It sits between the UART shift engines and the host-side register interface.

---
 rtl/uart_fifo_gen_if.sv | 29 ++
 rtl/uart_fifo_gen.sv | 108 ++++++++++
 tb/tb_uart_fifo_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_gen_if.sv
// Handshake/data bundle between the UART shift engines or host side (master)
// and the uart_fifo_gen storage block (slave).
interface uart_fifo_gen_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
);
    logic              n_clr_i;
    logic [DATA_W-1:0] data_i;
    logic              n_we_i;
    logic              n_re_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic [ADDR_W:0]   count_o;
    logic              empty_o;
    logic              full_o;
    logic              nearfull_o;
    logic              over_o;
    logic              under_o;

    modport master (
        output n_clr_i, data_i, n_we_i, n_re_i,
        input  data_o, valid_o, count_o, empty_o, full_o, nearfull_o, over_o, under_o
    );

    modport slave (
        input  n_clr_i, data_i, n_we_i, n_re_i,
        output data_o, valid_o, count_o, empty_o, full_o, nearfull_o, over_o, under_o
    );
endinterface

// File: rtl/uart_fifo_gen.sv
// Parametrised UART byte FIFO: full-depth usage, optional overwrite-oldest, sticky
// over/under flags, 1-cycle registered read. Define FIFO_TMR_EN for voted, scrubbed pointer state.
module uart_fifo_gen #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 12,
    parameter int NEARFULL_LVL = 3072,
    parameter int OVERWRITE    = 0
) (
    input logic            clk,
    input logic            rst,
    uart_fifo_gen_if.slave bus
);
    localparam int             DEPTH   = 1 << ADDR_W;
    localparam int             PW      = ADDR_W + 1;
    localparam logic [PW-1:0]  DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0]  NF_C    = PW'(NEARFULL_LVL);
    localparam logic           OVW_EN  = (OVERWRITE != 0);
`ifdef FIFO_TMR_EN
    localparam int NCOPY = 3;
`else
    localparam int NCOPY = 1;
`endif

    // All control state lives in one struct so protection applies uniformly.
    typedef struct packed {
        logic [PW-1:0] wr;
        logic [PW-1:0] rd;
        logic [PW-1:0] cnt;
        logic          over;
        logic          under;
    } st_t;

    st_t [NCOPY-1:0]   st_cp;
    st_t               st;
    st_t               nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              clr, we, re, empty, full, rd_ok, wr_ok, ovw;

`ifdef FIFO_TMR_EN
    // Bitwise 2-of-3 vote; every copy is reloaded from this each cycle.
    assign st = st_t'((st_cp[0] & st_cp[1]) | (st_cp[0] & st_cp[2]) | (st_cp[1] & st_cp[2]));
`else
    assign st = st_cp[0];
`endif

    always_comb begin
        clr   = ~bus.n_clr_i;
        we    = ~bus.n_we_i;
        re    = ~bus.n_re_i;
        empty = (st.cnt == '0);
        full  = (st.cnt == DEPTH_C);
        rd_ok = re & ~empty;
        // A read beside a full-FIFO write frees the slot, so overwrite only without one.
        ovw   = OVW_EN & we & full & ~re;
        wr_ok = we & (~full | rd_ok | ovw);
        nxt   = st;
        if (clr) begin
            nxt = '0;
        end else begin
            nxt.wr = st.wr + PW'(wr_ok);
            nxt.rd = st.rd + PW'(rd_ok | ovw);
            if (wr_ok & ~rd_ok & ~ovw)
                nxt.cnt = st.cnt + PW'(1);
            else if (rd_ok & ~wr_ok)
                nxt.cnt = st.cnt - PW'(1);
            nxt.over  = st.over  | (we & full & ~rd_ok);
            nxt.under = st.under | (re & empty);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            st_cp <= '0;
        else
            st_cp <= {NCOPY{nxt}};
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (~clr & wr_ok)
            mem[st.wr[ADDR_W-1:0]] <= bus.data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_ok;
            if (rd_ok)
                data_q <= mem[st.rd[ADDR_W-1:0]];
        end
    end

    assign bus.data_o     = data_q;
    assign bus.valid_o    = valid_q;
    assign bus.count_o    = st.cnt;
    assign bus.empty_o    = (st.cnt == '0);
    assign bus.full_o     = (st.cnt == DEPTH_C);
    assign bus.nearfull_o = (st.cnt >= NF_C);
    assign bus.over_o     = st.over;
    assign bus.under_o    = st.under;
endmodule

// File: tb/tb_uart_fifo_gen.sv
// Directed bench for uart_fifo_gen: drop-mode and overwrite-mode instances share one
// stimulus stream and are checked each cycle against a queue model plus literal expectations.
module tb_uart_fifo_gen;
    typedef logic [7:0] byteq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       n_clr = 1'b1;
    logic       n_we = 1'b1;
    logic       n_re = 1'b1;
    logic [7:0] din = 8'h00;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    uart_fifo_gen_if #(.DATA_W(8), .ADDR_W(4)) bus0 ();
    uart_fifo_gen_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();

    assign bus0.n_clr_i = n_clr;
    assign bus0.n_we_i  = n_we;
    assign bus0.n_re_i  = n_re;
    assign bus0.data_i  = din;
    assign bus1.n_clr_i = n_clr;
    assign bus1.n_we_i  = n_we;
    assign bus1.n_re_i  = n_re;
    assign bus1.data_i  = din;

    uart_fifo_gen #(.DATA_W(8), .ADDR_W(4), .NEARFULL_LVL(12), .OVERWRITE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    uart_fifo_gen #(.DATA_W(8), .ADDR_W(4), .NEARFULL_LVL(12), .OVERWRITE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Queue model: contents as a list, flags from the rules, no pointers.
    byteq_t     q0, q1;
    logic [7:0] m_data [2];
    logic       m_val [2];
    logic       m_ov [2];
    logic       m_un [2];

    task automatic mstep(input bit ovw_mode, inout byteq_t q, inout logic [7:0] d,
                         inout logic v, inout logic ov, inout logic un);
        int sz;
        bit w, r;
        sz = q.size();
        w  = !n_we;
        r  = !n_re;
        v  = 1'b0;
        if (!n_clr) begin
            q.delete(); d = 8'h00; ov = 1'b0; un = 1'b0;
        end else begin
            if (r && sz == 0) un = 1'b1;
            if (r && sz > 0) begin
                d = q.pop_front(); v = 1'b1;
            end
            if (w) begin
                if (sz < 16 || r) q.push_back(din);
                else begin
                    ov = 1'b1;
                    if (ovw_mode) begin
                        void'(q.pop_front()); q.push_back(din);
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q0.delete(); q1.delete();
                for (int g = 0; g < 2; g++) begin
                    m_data[g] = 8'h00; m_val[g] = 1'b0; m_ov[g] = 1'b0; m_un[g] = 1'b0;
                end
            end else begin
                mstep(1'b0, q0, m_data[0], m_val[0], m_ov[0], m_un[0]);
                mstep(1'b1, q1, m_data[1], m_val[1], m_ov[1], m_un[1]);
            end
        end
    end

    task automatic cmp(input int g, input int sz, input logic [7:0] d, input logic v,
                       input logic [4:0] c, input logic e, input logic f, input logic nf,
                       input logic ov, input logic un);
        chk($sformatf("m%0d_count", g), c, sz);
        chk($sformatf("m%0d_empty", g), e, sz == 0);
        chk($sformatf("m%0d_full", g), f, sz == 16);
        chk($sformatf("m%0d_nearfull", g), nf, sz >= 12);
        chk($sformatf("m%0d_data", g), d, m_data[g]);
        chk($sformatf("m%0d_valid", g), v, m_val[g]);
        chk($sformatf("m%0d_over", g), ov, m_ov[g]);
        chk($sformatf("m%0d_under", g), un, m_un[g]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, q0.size(), bus0.data_o, bus0.valid_o, bus0.count_o, bus0.empty_o,
                bus0.full_o, bus0.nearfull_o, bus0.over_o, bus0.under_o);
            cmp(1, q1.size(), bus1.data_o, bus1.valid_o, bus1.count_o, bus1.empty_o,
                bus1.full_o, bus1.nearfull_o, bus1.over_o, bus1.under_o);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input bit w, input bit r, input logic [7:0] d);
        n_we = ~w; n_re = ~r; din = d;
        @(posedge clk);
        @(negedge clk);
        n_we = 1'b1; n_re = 1'b1;
    endtask

    task automatic do_clr(input bit w, input logic [7:0] d);
        n_clr = 1'b0; n_we = ~w; din = d;
        @(posedge clk);
        @(negedge clk);
        n_clr = 1'b1; n_we = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", bus0.count_o, 0);
        chk("rst_empty", bus0.empty_o, 1);
        chk("rst_full", bus0.full_o, 0);
        chk("rst_data", bus0.data_o, 0);
        chk("rst_valid", bus0.valid_o, 0);
        chk("rst_flags", {bus0.nearfull_o, bus0.over_o, bus0.under_o}, 0);
        rst = 1'b1;

        // fill, drop on full, drain
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
        chk("fill_full", bus0.full_o, 1);
        chk("fill_count", bus0.count_o, 16);
        chk("fill_nearfull", bus0.nearfull_o, 1);
        chk("fill_over", bus0.over_o, 0);
        step(1, 0, 8'hAA);
        chk("drop_over", bus0.over_o, 1);
        chk("drop_count", bus0.count_o, 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'h00);
            chk("drain_data", bus0.data_o, i);
            chk("drain_valid", bus0.valid_o, 1);
        end
        chk("drain_empty", bus0.empty_o, 1);
        step(0, 0, 8'h00);
        chk("idle_valid", bus0.valid_o, 0);
        do_clr(0, 8'h00);

        // overwrite-oldest on the second instance
        for (int i = 0; i < 18; i++) step(1, 0, 8'(i));
        chk("ovw_count", bus1.count_o, 16);
        chk("ovw_over", bus1.over_o, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'h00);
            chk("ovw_data", bus1.data_o, i + 2);
        end
        do_clr(0, 8'h00);

        // simultaneous read+write at full
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(8'h40 + i));
            chk("rw16_data", bus0.data_o, (i < 16) ? (8'h20 + i) : (8'h40 + i - 16));
            chk("rw16_count", bus0.count_o, 16);
        end
        chk("rw16_over0", bus0.over_o, 0);
        chk("rw16_over1", bus1.over_o, 0);
        chk("rw16_count1", bus1.count_o, 16);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00);

        // simultaneous read+write at count 5
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i));
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(8'h70 + i));
            chk("rw5_data", bus0.data_o, (i < 5) ? (8'h60 + i) : (8'h70 + i - 5));
        end
        chk("rw5_count", bus0.count_o, 5);
        for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
        chk("rw5_empty", bus0.empty_o, 1);

        // read on empty with concurrent write
        step(1, 1, 8'h5A);
        chk("ue_under", bus0.under_o, 1);
        chk("ue_count", bus0.count_o, 1);
        chk("ue_valid", bus0.valid_o, 0);
        step(0, 1, 8'h00);
        chk("ue_data", bus0.data_o, 8'h5A);
        chk("ue_valid2", bus0.valid_o, 1);

        // synchronous clear with a write in the same cycle
        for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h30 + i));
        chk("clr_pre", bus0.count_o, 9);
        do_clr(1, 8'h77);
        chk("clr_count", bus0.count_o, 0);
        chk("clr_empty", bus0.empty_o, 1);
        chk("clr_flags", {bus0.over_o, bus0.under_o}, 0);
        chk("clr_data", bus0.data_o, 0);

        // async reset in the middle of a read
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h81 + i));
        n_re = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_valid", bus0.valid_o, 1);
        chk("mr_data", bus0.data_o, 8'h81);
        #1 rst = 1'b0;
        #1;
        chk("mr_rst_valid", bus0.valid_o, 0);
        chk("mr_rst_data", bus0.data_o, 0);
        chk("mr_rst_count", bus0.count_o, 0);
        chk("mr_rst_empty", bus0.empty_o, 1);
        n_re = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 8'hC3);
        step(0, 1, 8'h00);
        chk("post_rst_data", bus0.data_o, 8'hC3);

`ifdef FIFO_TMR_EN
        // upset one write-pointer copy; vote masks it and scrubbing repairs it
        do_clr(0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h91 + i));
        dut0.st_cp[1].wr = dut0.st_cp[1].wr ^ 5'h0A;
        step(1, 0, 8'h95);
        chk("tmr_scrub", dut0.st_cp[1].wr, 5);
        chk("tmr_count", bus0.count_o, 5);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'h00);
            chk("tmr_data", bus0.data_o, 8'h91 + i);
        end
`endif

        step(0, 0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
